// File: rtl/vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : vga_scanout
//  Purpose  : VGA raster timing generator and scan-out stage. Presents the
//             raster position to the renderer, takes its 1-bit pixel back
//             PIXEL_LATENCY cycles later, and drives sync plus 12-bit RGB to
//             the connector with blanking and sync re-aligned to that pixel.
//             Also emits a once-per-frame vblank_start tick for game logic.
//  Ports    : pixel_clk     in   pixel clock (25.175 MHz nominal)
//             rst           in   synchronous reset, active-high
//             pixel         in   renderer output, 1 = lit
//             test_mode     in   checkerboard select (VGA_TEST_PATTERN_EN only)
//             vga_x/vga_y   out  12-bit raster counters (not clamped)
//             vga_hs/vga_vs out  active-low sync
//             vga_r/g/b     out  4-bit colour channels
//             vblank_start  out  one-cycle pulse at start of vertical blank
//  Options  : define VGA_TEST_PATTERN_EN to add the test_mode port and the
//             16-pixel checkerboard generator.
//  Revision : 1.0  initial release
// ============================================================================
module vga_scanout #(
    parameter int H_ACTIVE      = 640,
    parameter int H_FP          = 16,
    parameter int H_SYNC        = 96,
    parameter int H_BP          = 48,
    parameter int V_ACTIVE      = 480,
    parameter int V_FP          = 10,
    parameter int V_SYNC        = 2,
    parameter int V_BP          = 33,
    parameter int PIXEL_LATENCY = 1
) (
    input  logic        pixel_clk,
    input  logic        rst,
    input  logic        pixel,
`ifdef VGA_TEST_PATTERN_EN
    input  logic        test_mode,
`endif
    output logic [11:0] vga_x,
    output logic [11:0] vga_y,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vblank_start
);

    localparam int          c_h_total    = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int          c_v_total    = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [11:0] c_h_last     = 12'(c_h_total - 1);
    localparam logic [11:0] c_v_last     = 12'(c_v_total - 1);
    localparam logic [11:0] c_h_active   = 12'(H_ACTIVE);
    localparam logic [11:0] c_v_active   = 12'(V_ACTIVE);
    localparam logic [11:0] c_hs_first   = 12'(H_ACTIVE + H_FP);
    localparam logic [11:0] c_hs_last    = 12'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [11:0] c_vs_first   = 12'(V_ACTIVE + V_FP);
    localparam logic [11:0] c_vs_last    = 12'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam int          c_dly_top    = PIXEL_LATENCY - 1;

    // Raster counters
    logic [11:0] r_h_cnt;
    logic [11:0] r_v_cnt;

    // Stage-0 timing decoded from the counters
    logic        w_h_wrap;
    logic        w_v_wrap;
    logic        w_active0;
    logic        w_hs0;
    logic        w_vs0;

    // Alignment delay line; index 0 is the newest entry
    logic [c_dly_top:0] r_active_dly;
    logic [c_dly_top:0] r_hs_dly;
    logic [c_dly_top:0] r_vs_dly;

    // Output register
    logic        w_lit;
    logic        r_hs;
    logic        r_vs;
    logic [11:0] r_rgb;
    logic        r_vblank;

    assign w_h_wrap  = (r_h_cnt == c_h_last);
    assign w_v_wrap  = (r_v_cnt == c_v_last);
    assign w_active0 = (r_h_cnt < c_h_active) && (r_v_cnt < c_v_active);
    assign w_hs0     = !((r_h_cnt >= c_hs_first) && (r_h_cnt <= c_hs_last));
    // vsync is decoded from the line counter only, so it spans whole lines
    assign w_vs0     = !((r_v_cnt >= c_vs_first) && (r_v_cnt <= c_vs_last));

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (w_h_wrap) begin
            r_h_cnt <= '0;
            r_v_cnt <= w_v_wrap ? 12'd0 : r_v_cnt + 12'd1;
        end else begin
            r_h_cnt <= r_h_cnt + 12'd1;
        end
    end

    // Delays blanking/sync by the renderer latency so they line up with the
    // pixel that belongs to the same coordinates. Reset fills it with the
    // idle (blanked, sync inactive) state so no stale sync leaks out.
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_active_dly <= '0;
            r_hs_dly     <= '1;
            r_vs_dly     <= '1;
        end else begin
            r_active_dly[0] <= w_active0;
            r_hs_dly[0]     <= w_hs0;
            r_vs_dly[0]     <= w_vs0;
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                r_active_dly[i] <= r_active_dly[i-1];
                r_hs_dly[i]     <= r_hs_dly[i-1];
                r_vs_dly[i]     <= r_vs_dly[i-1];
            end
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    // The checkerboard only needs bit 4 of each coordinate, so only that bit
    // travels down the delay line.
    logic [c_dly_top:0] r_x4_dly;
    logic [c_dly_top:0] r_y4_dly;

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_x4_dly <= '0;
            r_y4_dly <= '0;
        end else begin
            r_x4_dly[0] <= r_h_cnt[4];
            r_y4_dly[0] <= r_v_cnt[4];
            for (int i = 1; i < PIXEL_LATENCY; i++) begin
                r_x4_dly[i] <= r_x4_dly[i-1];
                r_y4_dly[i] <= r_y4_dly[i-1];
            end
        end
    end

    assign w_lit = test_mode ? (r_x4_dly[c_dly_top] ^ r_y4_dly[c_dly_top]) : pixel;
`else
    assign w_lit = pixel;
`endif

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            r_hs     <= 1'b1;
            r_vs     <= 1'b1;
            r_rgb    <= 12'h000;
            r_vblank <= 1'b0;
        end else begin
            r_hs     <= r_hs_dly[c_dly_top];
            r_vs     <= r_vs_dly[c_dly_top];
            // Gating by the delayed active flag keeps garbage on pixel during
            // blanking away from the DAC.
            r_rgb    <= (r_active_dly[c_dly_top] && w_lit) ? 12'hFFF : 12'h000;
            // Taken straight from the counters: game logic wants the earliest
            // notice of blanking, not the pin-aligned one.
            r_vblank <= (r_h_cnt == 12'd0) && (r_v_cnt == c_v_active);
        end
    end

    assign vga_x        = r_h_cnt;
    assign vga_y        = r_v_cnt;
    assign vga_hs       = r_hs;
    assign vga_vs       = r_vs;
    assign vga_r        = r_rgb[11:8];
    assign vga_g        = r_rgb[7:4];
    assign vga_b        = r_rgb[3:0];
    assign vblank_start = r_vblank;

endmodule
`default_nettype wire

// File: tb/tb_vga_scanout.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_scanout
//  Purpose  : Scoreboard bench for vga_scanout. Expected transitions of
//             hsync, vsync, vblank_start and lit RGB, plus coordinate samples,
//             are queued by the stimulus; a monitor pops and compares them as
//             the DUT produces them. Horizontal timing uses the 640x480
//             defaults; the frame is shortened vertically (20 active lines,
//             FP 3, sync 2, BP 5 -> 30 lines) so several frames fit in the run.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vga_scanout;

    // Hand-derived timing for the instantiated parameter set, cycle 0 being
    // the first cycle showing (0,0) after reset, PIXEL_LATENCY = 1.
    localparam int H_TOT   = 800;            // 640+16+96+48
    localparam int V_TOT   = 30;             // 20+3+2+5
    localparam int V_ACT   = 20;
    localparam int FRAME   = 24000;          // 800*30
    localparam int HS_FALL = 658;            // 656 + 2 cycles of latency
    localparam int HS_LOW  = 96;
    localparam int LIT_ON  = 2;              // x=0 shows at the pins 2 cycles later
    localparam int LIT_OFF = 642;            // first dark cycle after x=639
    localparam int VB_AT   = 16001;          // 20*800 + 1
    localparam int VS_FALL = 18402;          // 23*800 + 2
    localparam int VS_LOW  = 1600;           // 2 full lines
    localparam int LIT_PER_FRAME = 12800;    // 640*20

    typedef struct {
        int cyc;
        bit lvl;
    } ev_t;

    typedef struct {
        int cyc;
        int x;
        int y;
    } co_t;

    logic        pixel_clk = 1'b0;
    logic        rst       = 1'b1;
    logic        pixel     = 1'b0;
    logic [11:0] vga_x;
    logic [11:0] vga_y;
    logic        vga_hs;
    logic        vga_vs;
    logic [3:0]  vga_r;
    logic [3:0]  vga_g;
    logic [3:0]  vga_b;
    logic        vblank_start;

    ev_t q_hs[$];
    ev_t q_vs[$];
    ev_t q_vb[$];
    ev_t q_px[$];
    co_t q_co[$];

    int  n_checks = 0;
    int  n_err    = 0;
    int  cyc      = 0;
    int  lit_cnt  = 0;
    int  pix_mode = 0;
    bit  armed    = 0;
    bit  p_hs, p_vs, p_vb, p_px;

    vga_scanout #(
        .H_ACTIVE      (640),
        .H_FP          (16),
        .H_SYNC        (96),
        .H_BP          (48),
        .V_ACTIVE      (20),
        .V_FP          (3),
        .V_SYNC        (2),
        .V_BP          (5),
        .PIXEL_LATENCY (1)
    ) dut (
        .pixel_clk    (pixel_clk),
        .rst          (rst),
        .pixel        (pixel),
        .vga_x        (vga_x),
        .vga_y        (vga_y),
        .vga_hs       (vga_hs),
        .vga_vs       (vga_vs),
        .vga_r        (vga_r),
        .vga_g        (vga_g),
        .vga_b        (vga_b),
        .vblank_start (vblank_start)
    );

    always #20 pixel_clk = ~pixel_clk;

    // ---------------- renderer model (one-cycle registered renderer) -------
    initial begin
        bit nxt;
        forever begin
            @(negedge pixel_clk);
            case (pix_mode)
                0:       nxt = (vga_x == 12'd100) && (vga_y == 12'd10);
                1:       nxt = 1'b1;
                default: nxt = !((vga_x < 12'd640) && (vga_y < 12'd20));
            endcase
            @(posedge pixel_clk);
            #1 pixel = nxt;
        end
    end

    // ---------------- scoreboard helpers ----------------------------------
    function automatic string sig_name(input int s);
        case (s)
            0:       return "hsync";
            1:       return "vsync";
            2:       return "vblank";
            default: return "rgb_lit";
        endcase
    endfunction

    task automatic push_ev(input int s, input int c, input bit l);
        ev_t e;
        e.cyc = c;
        e.lvl = l;
        case (s)
            0:       q_hs.push_back(e);
            1:       q_vs.push_back(e);
            2:       q_vb.push_back(e);
            default: q_px.push_back(e);
        endcase
    endtask

    task automatic push_co(input int c, input int x, input int y);
        co_t e;
        e.cyc = c;
        e.x   = x;
        e.y   = y;
        q_co.push_back(e);
    endtask

    // Queue every transition of one frame starting at base whose cycle is < lim.
    task automatic push_frame(input int base, input int lim, input bit lit);
        int c0;
        for (int l = 0; l < V_TOT; l++) begin
            c0 = base + l * H_TOT;
            if (c0 + HS_FALL < lim)          push_ev(0, c0 + HS_FALL, 1'b0);
            if (c0 + HS_FALL + HS_LOW < lim) push_ev(0, c0 + HS_FALL + HS_LOW, 1'b1);
            if (lit && l < V_ACT) begin
                if (c0 + LIT_ON < lim)  push_ev(3, c0 + LIT_ON, 1'b1);
                if (c0 + LIT_OFF < lim) push_ev(3, c0 + LIT_OFF, 1'b0);
            end
        end
        if (base + VB_AT < lim)              push_ev(2, base + VB_AT, 1'b1);
        if (base + VB_AT + 1 < lim)          push_ev(2, base + VB_AT + 1, 1'b0);
        if (base + VS_FALL < lim)            push_ev(1, base + VS_FALL, 1'b0);
        if (base + VS_FALL + VS_LOW < lim)   push_ev(1, base + VS_FALL + VS_LOW, 1'b1);
    endtask

    task automatic chk_edge(input int s, input bit l);
        ev_t e;
        bit  have = 0;
        n_checks++;
        case (s)
            0: if (q_hs.size() > 0) begin e = q_hs.pop_front(); have = 1; end
            1: if (q_vs.size() > 0) begin e = q_vs.pop_front(); have = 1; end
            2: if (q_vb.size() > 0) begin e = q_vb.pop_front(); have = 1; end
            default: if (q_px.size() > 0) begin e = q_px.pop_front(); have = 1; end
        endcase
        if (!have) begin
            n_err++;
            $display("FAIL %s_edge: got transition to %0d at cycle %0d, required none",
                     sig_name(s), l, cyc);
        end else if (e.cyc != cyc || e.lvl != l) begin
            n_err++;
            $display("FAIL %s_edge: got level %0d at cycle %0d, required level %0d at cycle %0d",
                     sig_name(s), l, cyc, e.lvl, e.cyc);
        end
    endtask

    task automatic chk_coord();
        co_t e;
        if (q_co.size() > 0 && q_co[0].cyc == cyc) begin
            e = q_co.pop_front();
            n_checks++;
            if (int'(vga_x) != e.x || int'(vga_y) != e.y) begin
                n_err++;
                $display("FAIL coord@%0d: got (%0d,%0d), required (%0d,%0d)",
                         cyc, vga_x, vga_y, e.x, e.y);
            end
        end
    endtask

    // ---------------- monitor ---------------------------------------------
    initial begin
        bit px;
        forever begin
            @(posedge pixel_clk);
            #1;
            px = ({vga_r, vga_g, vga_b} == 12'hFFF);
            if (rst) begin
                armed   = 1;
                cyc     = 0;
                lit_cnt = 0;
                n_checks++;
                if (vga_x !== 12'd0 || vga_y !== 12'd0 || vga_hs !== 1'b1 || vga_vs !== 1'b1 ||
                    {vga_r, vga_g, vga_b} !== 12'h000 || vblank_start !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_state: got x=%0d y=%0d hs=%b vs=%b rgb=%h vb=%b, required x=0 y=0 hs=1 vs=1 rgb=000 vb=0",
                             vga_x, vga_y, vga_hs, vga_vs, {vga_r, vga_g, vga_b}, vblank_start);
                end
                chk_coord();
            end else if (armed) begin
                cyc++;
                chk_coord();
                if (vga_hs != p_hs)       chk_edge(0, vga_hs);
                if (vga_vs != p_vs)       chk_edge(1, vga_vs);
                if (vblank_start != p_vb) chk_edge(2, vblank_start);
                if (px != p_px)           chk_edge(3, px);
                if (px) lit_cnt++;
            end
            p_hs = vga_hs;
            p_vs = vga_vs;
            p_vb = vblank_start;
            p_px = px;
        end
    end

    // ---------------- stimulus --------------------------------------------
    task automatic run_to(input int c);
        int guard = 0;
        while (cyc != c && guard < 70000) begin
            @(posedge pixel_clk);
            #2;
            guard++;
        end
        if (cyc != c) begin
            n_checks++;
            n_err++;
            $display("FAIL run_to: got cycle %0d, required cycle %0d", cyc, c);
        end
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        @(posedge pixel_clk);
        #2 rst = 1'b0;
    endtask

    task automatic chk_drained(input string tag);
        int sz[4];
        sz[0] = q_hs.size();
        sz[1] = q_vs.size();
        sz[2] = q_vb.size();
        sz[3] = q_px.size();
        for (int s = 0; s < 4; s++) begin
            n_checks++;
            if (sz[s] != 0) begin
                n_err++;
                $display("FAIL %s_%s_pending: got %0d transitions never seen, required 0",
                         tag, sig_name(s), sz[s]);
            end
        end
        n_checks++;
        if (q_co.size() != 0) begin
            n_err++;
            $display("FAIL %s_coord_pending: got %0d samples never taken, required 0",
                     tag, q_co.size());
        end
    endtask

    task automatic chk_lit(input string tag, input int got, input int req);
        n_checks++;
        if (got != req) begin
            n_err++;
            $display("FAIL %s: got %0d lit cycles, required %0d", tag, got, req);
        end
    endtask

    initial begin
        int snap;

        // Frame 0: single-pixel renderer; frame 1: pixel tied high;
        // frame 2: pixel high only outside the active area, reset mid-frame.
        push_co(0, 0, 0);
        push_co(799, 799, 0);
        push_co(800, 0, 1);
        push_co(8100, 100, 10);
        push_co(23999, 799, 29);
        push_co(FRAME, 0, 0);
        push_co(2 * FRAME + 15 * H_TOT + 300, 300, 15);
        push_frame(0, FRAME, 1'b0);
        push_ev(3, 10 * H_TOT + 100 + 2, 1'b1);
        push_ev(3, 10 * H_TOT + 100 + 3, 1'b0);
        push_frame(FRAME, 2 * FRAME, 1'b1);
        push_frame(2 * FRAME, 2 * FRAME + 15 * H_TOT + 301, 1'b0);

        rst = 1'b1;
        repeat (3) @(posedge pixel_clk);
        #2 rst = 1'b0;

        run_to(23000);
        pix_mode = 1;
        run_to(FRAME);
        chk_lit("lit_frame0", lit_cnt, 1);
        snap = lit_cnt;
        run_to(47000);
        pix_mode = 2;
        run_to(2 * FRAME);
        chk_lit("lit_frame1", lit_cnt - snap, LIT_PER_FRAME);

        // Reset at line 15, x=300
        run_to(2 * FRAME + 15 * H_TOT + 300);
        chk_drained("pre_reset1");
        pix_mode = 1;
        pulse_rst();
        push_co(1, 1, 0);
        push_frame(0, 23 * H_TOT + 701, 1'b1);

        // Reset again with both syncs low (line 23, x=700)
        run_to(23 * H_TOT + 700);
        chk_lit("lit_after_reset1", lit_cnt, LIT_PER_FRAME);
        chk_drained("pre_reset2");
        pulse_rst();
        push_co(658, 658, 0);
        push_frame(0, 1001, 1'b1);
        run_to(1000);
        chk_drained("final");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
